despachador_minero: RTL and testbench

- Hardware job dispatcher: the host/initiator side of the nonce-search system.
- Accepts mining jobs (96-bit block header fragment plus 8-bit target) over a valid/ready interface and drives the miner's data_in, target and reset.
- Waits for the miner's finished pulse, or a timeout, then presents nonce_out, a cycle count and a timeout flag on a valid/ready result interface.
- Replaces the behavioural probador_sistema stimulus in system-level benches and in the final integration.

---
 rtl/despachador_minero.sv | 97 +++++++++
 tb/tb_despachador_minero.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/despachador_minero.sv
// despachador_minero: accepts mining jobs, drives the miner through LOAD/RUN and
// returns the found nonce (or a timeout) on a single-entry valid/ready result port.
module despachador_minero #(
    parameter int BYTE       = 8,
    parameter int RST_CICLOS = 2,
    parameter int MAX_CICLOS = 1000000,
    parameter int CNT_W      = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                job_valid,
    output logic                job_ready,
    input  logic [12*BYTE-1:0]  job_data,
    input  logic [7:0]          job_target,
    output logic                miner_reset,
    output logic [12*BYTE-1:0]  miner_data_in,
    output logic [7:0]          miner_target,
    input  logic                miner_finished,
    input  logic [31:0]         miner_nonce,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [31:0]         res_nonce,
    output logic                res_timeout,
    output logic [CNT_W-1:0]    res_cycles,
    output logic                busy
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CICLOS - 1);
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(MAX_CICLOS - 1);

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 miner_reset_q;
    logic [12*BYTE-1:0]   data_q;
    logic [7:0]           target_q;
    logic                 res_valid_q;
    logic [31:0]          res_nonce_q;
    logic                 res_timeout_q;
    logic [CNT_W-1:0]     res_cycles_q;

    assign job_ready     = (state_q == IDLE) && !reset;
    assign busy          = (state_q == LOAD) || (state_q == RUN);
    assign miner_reset   = miner_reset_q;
    assign miner_data_in = data_q;
    assign miner_target  = target_q;
    assign res_valid     = res_valid_q;
    assign res_nonce     = res_nonce_q;
    assign res_timeout   = res_timeout_q;
    assign res_cycles    = res_cycles_q;

    // One counter serves both the LOAD hold and the RUN budget.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            miner_reset_q <= 1'b1;
            data_q        <= '0;
            target_q      <= '0;
            res_valid_q   <= 1'b0;
            res_nonce_q   <= '0;
            res_timeout_q <= 1'b0;
            res_cycles_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (job_valid) begin
                    data_q   <= job_data;
                    target_q <= job_target;
                    cnt_q    <= '0;
                    state_q  <= LOAD;
                end
                LOAD: if (cnt_q == RST_LAST) begin
                    cnt_q         <= '0;
                    miner_reset_q <= 1'b0;
                    state_q       <= RUN;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                RUN: if (miner_finished || cnt_q == RUN_LAST) begin
                    res_nonce_q   <= miner_finished ? miner_nonce : 32'd0;
                    res_timeout_q <= !miner_finished;
                    res_cycles_q  <= cnt_q;
                    res_valid_q   <= 1'b1;
                    miner_reset_q <= 1'b1;
                    state_q       <= DONE;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                DONE: if (res_ready) begin
                    res_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_despachador_minero.sv
// tb_despachador_minero: directed jobs with the bench acting as miner; a scoreboard
// queue holds expected results and a negedge monitor checks each result handshake.
module tb_despachador_minero;
    localparam int CNT_W = 32;

    typedef struct packed {
        logic [31:0]      nonce;
        logic [CNT_W-1:0] cycles;
        logic             timeout;
    } res_t;

    logic              clk = 0;
    logic              reset = 1;
    logic              job_valid = 0;
    logic              job_ready;
    logic [95:0]       job_data = '0;
    logic [7:0]        job_target = '0;
    logic              miner_reset;
    logic [95:0]       miner_data_in;
    logic [7:0]        miner_target;
    logic              miner_finished = 0;
    logic [31:0]       miner_nonce = '0;
    logic              res_valid;
    logic              res_ready = 1;
    logic [31:0]       res_nonce;
    logic              res_timeout;
    logic [CNT_W-1:0]  res_cycles;
    logic              busy;

    int checks = 0;
    int failures = 0;
    res_t exp_q[$];

    despachador_minero #(.BYTE(8), .RST_CICLOS(2), .MAX_CICLOS(16), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .job_valid(job_valid), .job_ready(job_ready),
        .job_data(job_data), .job_target(job_target), .miner_reset(miner_reset),
        .miner_data_in(miner_data_in), .miner_target(miner_target),
        .miner_finished(miner_finished), .miner_nonce(miner_nonce),
        .res_valid(res_valid), .res_ready(res_ready), .res_nonce(res_nonce),
        .res_timeout(res_timeout), .res_cycles(res_cycles), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (!reset && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                check("res_nonce", res_nonce, e.nonce);
                check("res_cycles", res_cycles, e.cycles);
                check("res_timeout", res_timeout, e.timeout);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a job, wait for acceptance, then verify the 2-cycle LOAD and entry to RUN.
    task automatic send_job(input logic [95:0] d, input logic [7:0] t, input bit fin_load);
        int n = 0;
        job_valid = 1;
        job_data = d;
        job_target = t;
        while (!job_ready && n < 50) begin
            tick();
            n++;
        end
        check("job_ready_wait", job_ready, 1);
        tick();
        job_valid = 0;
        job_data = ~d;
        if (fin_load) begin
            miner_finished = 1;
            miner_nonce = 32'hDEAD_DEAD;
        end
        check("load1_miner_reset", miner_reset, 1);
        check("load_busy", busy, 1);
        check("miner_data_in", miner_data_in, d);
        check("miner_target", miner_target, t);
        tick();
        check("load2_miner_reset", miner_reset, 1);
        tick();
        check("run_miner_reset", miner_reset, 0);
        miner_finished = 0;
    endtask

    // Entered in the first RUN cycle (counter 0); finishes at counter k or lets it time out.
    task automatic run_job(input int k, input logic [31:0] nonce, input bit fin, input res_t e);
        exp_q.push_back(e);
        repeat (k) tick();
        if (fin) begin
            miner_finished = 1;
            miner_nonce = nonce;
        end
        tick();
        miner_finished = 0;
        check("done_res_valid", res_valid, 1);
        check("done_miner_reset", miner_reset, 1);
        check("done_busy", busy, 0);
        if (res_ready) begin
            tick();
            check("res_valid_pulse", res_valid, 0);
        end
    endtask

    initial begin
        tick();
        check("rst_job_ready", job_ready, 0);
        check("rst_miner_reset", miner_reset, 1);
        check("rst_res_valid", res_valid, 0);
        check("rst_data", miner_data_in, 0);
        check("rst_res_cycles", res_cycles, 0);
        tick();
        reset = 0;
        #1;
        check("idle_job_ready", job_ready, 1);
        check("idle_busy", busy, 0);

        // Normal job
        send_job(96'h0123_4567_89AB_CDEF_0011_2233, 8'h10, 0);
        run_job(10, 32'h0000_1234, 1, '{32'h1234, 10, 1'b0});

        // Timeout
        send_job(96'hAAAA_0000_BBBB_1111_CCCC_2222, 8'h05, 0);
        run_job(15, 32'h0, 0, '{32'h0, 15, 1'b1});

        // Finished and timeout coincide
        send_job(96'h1111_2222_3333_4444_5555_6666, 8'h22, 0);
        run_job(15, 32'h0000_CAFE, 1, '{32'hCAFE, 15, 1'b0});

        // Backpressure with a new job waiting
        res_ready = 0;
        send_job(96'hFEDC_BA98_7654_3210_0F0F_0F0F, 8'h33, 0);
        run_job(3, 32'h0000_BEEF, 1, '{32'hBEEF, 3, 1'b0});
        job_valid = 1;
        job_data = 96'h9999_8888_7777_6666_5555_4444;
        job_target = 8'h44;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_res_valid", res_valid, 1);
            check("bp_res_nonce", res_nonce, 32'hBEEF);
            check("bp_res_cycles", res_cycles, 3);
            check("bp_job_ready", job_ready, 0);
            check("bp_data_held", miner_data_in, 96'hFEDC_BA98_7654_3210_0F0F_0F0F);
        end
        res_ready = 1;
        tick();
        check("bp_res_valid_drop", res_valid, 0);
        check("bp_job_ready_after", job_ready, 1);
        check("bp_data_not_yet", miner_data_in, 96'hFEDC_BA98_7654_3210_0F0F_0F0F);
        tick();
        job_valid = 0;
        check("bp_new_data", miner_data_in, 96'h9999_8888_7777_6666_5555_4444);
        check("bp_new_busy", busy, 1);
        tick();
        tick();
        check("bp_run_miner_reset", miner_reset, 0);
        run_job(1, 32'h0000_4444, 1, '{32'h4444, 1, 1'b0});

        // Reset in the middle of RUN at counter 7
        send_job(96'h5A5A_5A5A_5A5A_5A5A_5A5A_5A5A, 8'h77, 0);
        repeat (7) tick();
        reset = 1;
        tick();
        reset = 0;
        #1;
        check("mid_job_ready", job_ready, 1);
        check("mid_miner_reset", miner_reset, 1);
        check("mid_res_valid", res_valid, 0);
        check("mid_data", miner_data_in, 0);
        check("mid_busy", busy, 0);
        send_job(96'h0000_0000_0000_0000_0000_0001, 8'h01, 0);
        run_job(0, 32'h0000_0077, 1, '{32'h77, 0, 1'b0});

        // Back-to-back, finished held high during the second LOAD
        send_job(96'h0A0A_0B0B_0C0C_0D0D_0E0E_0F0F, 8'h0A, 0);
        run_job(2, 32'h0000_1111, 1, '{32'h1111, 2, 1'b0});
        send_job(96'hA0A0_B0B0_C0C0_D0D0_E0E0_F0F0, 8'hA0, 1);
        run_job(4, 32'h0000_2222, 1, '{32'h2222, 4, 1'b0});

        tick();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
